// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: S-box tables, permutation layers and defaults
// used by both the encoder and the decoder.
package present_pkg;

    localparam int unsigned KEY_W   = 80;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned RC_W    = 5;

    localparam int unsigned NR_ROUNDS = 32;
    localparam logic [KEY_W-1:0] INITIAL_KEY = 80'h0;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN,
        ST_DONE
    } state_t;

    // Sixteen parallel nibble substitutions
    function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = SBOX[x[4*i +: 4]];
        end
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = INV_SBOX[x[4*i +: 4]];
        end
        return y;
    endfunction

    // Bit i moves to (16*i) mod 63; bit 63 stays put
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(16 * i) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_key_update.sv
// One step of the PRESENT-80 key schedule (purely combinational).
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [RC_W-1:0]  round,
    output logic [KEY_W-1:0] next_key_c
);

    logic [KEY_W-1:0] rot;

    always_comb begin
        rot        = {key[18:0], key[79:19]};
        next_key_c = rot;
        next_key_c[79:76] = SBOX[rot[79:76]];
        next_key_c[19:15] = rot[19:15] ^ round;
    end

endmodule

// File: rtl/present_encoder.sv
// PRESENT-80 block encryptor, one round per falling clock edge; the result
// drives a shared bus only while done is high.
module present_encoder #(
    parameter int unsigned NR_ROUNDS = present_pkg::NR_ROUNDS,
    parameter logic [79:0] INITIAL_KEY = present_pkg::INITIAL_KEY
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [1:0]  pl,
    input  logic [79:0] in_text,
    output logic [63:0] text,
    output logic        done,
    output logic        busy
);

    import present_pkg::*;

    logic [KEY_W-1:0]   master_key;
    logic [KEY_W-1:0]   rkey;
    logic [KEY_W-1:0]   next_rkey;
    logic [BLOCK_W-1:0] word;
    logic [CNT_W-1:0]   cnt;
    state_t             state;

    present_key_update u_key_update (
        .key        (rkey),
        .round      (cnt[RC_W-1:0]),
        .next_key_c (next_rkey)
    );

    // Key load has priority over everything, including a block in flight
    always_ff @(negedge clk or negedge n_reset) begin
        if (!n_reset) begin
            master_key <= INITIAL_KEY;
            rkey       <= INITIAL_KEY;
            word       <= '0;
            cnt        <= '0;
            state      <= ST_IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else if (pl[1]) begin
            master_key <= in_text;
            state      <= ST_IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (pl[0]) begin
                        word  <= in_text[BLOCK_W-1:0];
                        rkey  <= master_key;
                        cnt   <= CNT_W'(1);
                        state <= ST_RUN;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    word <= p_layer(sbox_layer(word ^ rkey[79:16]));
                    rkey <= next_rkey;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NR_ROUNDS - 1)) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    word  <= word ^ rkey[79:16];
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign text = done ? word : {BLOCK_W{1'bz}};

endmodule
